// File: rtl/dbg_vga_scanner.sv
// Sweeps the debug-probe grid once per frame and writes ASCII glyphs into character RAM.
// Optional `DBG_SCAN_FREEZE_EN: freeze=1 blocks new frames and drops any pending request.
module dbg_vga_scanner #(
  parameter int ROW_FIRST = 1,
  parameter int ROW_LAST  = 6,
  parameter int ADDR_W    = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_freeze,
  output logic [7:0]        o_scan_row,
  output logic [7:0]        o_scan_col,
  input  logic              i_vga_space,
  input  logic [3:0]        i_vga_data,
  output logic              o_ch_we,
  output logic [ADDR_W-1:0] o_ch_addr,
  output logic [7:0]        o_ch_data,
  input  logic              i_ch_ack,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_cnt
);

  localparam logic [7:0] ROW_F8 = 8'(ROW_FIRST);
  localparam logic [7:0] ROW_L8 = 8'(ROW_LAST);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_row;
  logic [7:0]          r_col;
  logic                r_pending;
  logic [7:0]          r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_cnt;
  logic                w_start;
  logic                w_pend_clr;
  logic                w_go;
  logic                w_last_col;
  logic                w_last_row;
  logic [2:0]          w_row_off;
  logic [7:0]          w_glyph;

`ifdef DBG_SCAN_FREEZE_EN
  assign w_start    = i_frame_start & ~i_freeze;
  assign w_pend_clr = i_freeze;
`else
  logic w_unused_freeze;
  assign w_unused_freeze = i_freeze;
  assign w_start    = i_frame_start;
  assign w_pend_clr = 1'b0;
`endif

  assign w_go       = w_start | (r_pending & ~w_pend_clr);
  assign w_last_col = (r_col == 8'hFF);
  assign w_last_row = (r_row == ROW_L8);
  assign w_row_off  = 3'(r_row - ROW_F8);

  // Letters use 0x37+n so that 10 lands on 'A'.
  always_comb begin
    w_glyph = 8'h20;
    if (!i_vga_space) begin
      if (i_vga_data < 4'd10) w_glyph = 8'h30 + {4'h0, i_vga_data};
      else                    w_glyph = 8'h37 + {4'h0, i_vga_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_go) w_next = S_DRIVE;
      S_DRIVE:  w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_WRITE;
      S_WRITE:  if (i_ch_ack) w_next = (w_last_col && w_last_row) ? S_DONE : S_DRIVE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row     <= ROW_F8;
      r_col     <= 8'h00;
      r_pending <= 1'b0;
      r_data    <= 8'h00;
      r_addr    <= '0;
      r_cnt     <= 16'h0000;
    end else begin
      // A start seen while busy (including DONE) is remembered one-deep.
      if (r_state == S_IDLE) begin
        if (w_go || w_pend_clr) r_pending <= 1'b0;
      end else if (w_pend_clr) begin
        r_pending <= 1'b0;
      end else if (w_start) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_row <= ROW_F8;
            r_col <= 8'h00;
          end
        end
        S_SAMPLE: begin
          r_data <= w_glyph;
          r_addr <= ADDR_W'({w_row_off, r_col});
        end
        S_WRITE: begin
          if (i_ch_ack) begin
            r_col <= r_col + 8'h01;
            if (w_last_col) begin
              if (w_last_row) r_cnt <= r_cnt + 16'h0001;
              else            r_row <= r_row + 8'h01;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_scan_row   = r_row;
  assign o_scan_col   = r_col;
  assign o_ch_we      = (r_state == S_WRITE);
  assign o_ch_addr    = r_addr;
  assign o_ch_data    = r_data;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = (r_state == S_DONE);
  assign o_frame_cnt  = r_cnt;

endmodule

// File: tb/tb_dbg_vga_scanner.sv
// Directed bench for dbg_vga_scanner: a debug-mux model feeds the scanner and every
// accepted character write is checked against a queue of expected {addr, glyph}.
module tb_dbg_vga_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        freeze;
  logic [7:0]  scan_row;
  logic [7:0]  scan_col;
  logic        vga_space;
  logic [3:0]  vga_data;
  logic        ch_we;
  logic [10:0] ch_addr;
  logic [7:0]  ch_data;
  logic        ch_ack;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_cmp  = 0;
  int n_err  = 0;
  int writes = 0;
  int mode   = 0;
  logic [18:0] sb[$];
  string hexdig = "0123456789ABCDEF";

  always #5 clk = ~clk;

  dbg_vga_scanner dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_freeze(freeze),
    .o_scan_row(scan_row), .o_scan_col(scan_col),
    .i_vga_space(vga_space), .i_vga_data(vga_data),
    .o_ch_we(ch_we), .o_ch_addr(ch_addr), .o_ch_data(ch_data), .i_ch_ack(ch_ack),
    .o_busy(busy), .o_frame_done(frame_done), .o_frame_cnt(frame_cnt)
  );

  // Mode 1 plants a few distinctive cells on row 2 to exercise every glyph class.
  function automatic logic [4:0] mux_val(input logic [7:0] r, input logic [7:0] c, input int m);
    logic [3:0] nib;
    nib = 4'(c[1:0]) + r[3:0];
    if (m == 1 && r == 8'd2 && c < 8'd5) begin
      case (c)
        8'd0:    return {1'b0, 4'h0};
        8'd1:    return {1'b0, 4'h9};
        8'd2:    return {1'b0, 4'hA};
        8'd3:    return {1'b0, 4'hF};
        default: return {1'b1, 4'h5};
      endcase
    end
    return {1'b0, nib};
  endfunction

  function automatic logic [7:0] glyph(input logic [4:0] v);
    if (v[4]) return 8'h20;
    return 8'(hexdig[v[3:0]]);
  endfunction

  assign {vga_space, vga_data} = mux_val(scan_row, scan_col, mode);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int r = 1; r <= 6; r++)
      for (int c = 0; c < 256; c++)
        sb.push_back({3'(r - 1), 8'(c), glyph(mux_val(8'(r), 8'(c), mode))});
  endtask

  task automatic start_frame();
    fs = 1'b1;
    push_frame();
    step();
    fs = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int exp_len, input string tag);
    int n;
    n = n0;
    while (!frame_done && n < exp_len + 50) begin
      step();
      n++;
    end
    check(tag, 64'(n), 64'(exp_len));
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst && ch_we && ch_ack) begin
      writes++;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      check("write", {45'h0, ch_addr, ch_data}, {45'h0, e});
    end
  end

  initial begin
    int n;
    rst = 1'b1; fs = 1'b0; ch_ack = 1'b1;
`ifdef DBG_SCAN_FREEZE_EN
    freeze = 1'b0;
`else
    freeze = 1'b1;
`endif
    repeat (3) step();
    check("rst_row", 64'(scan_row), 64'd1);
    check("rst_outs", {18'h0, scan_col, ch_we, ch_addr, ch_data, busy, frame_done, frame_cnt}, 64'h0);
    rst = 1'b0;
    step();

    // Abandon a frame with reset at cell 0x2A0.
    start_frame();
    n = 0;
    while (!(ch_we && ch_addr == 11'h2A0) && n < 5000) begin step(); n++; end
    check("a_reach_2a0", 64'(n < 5000), 64'd1);
    rst = 1'b1;
    step();
    check("a_rst_we_busy", {62'h0, ch_we, busy}, 64'h0);
    check("a_rst_cnt", 64'(frame_cnt), 64'h0);
    sb.delete();
    rst = 1'b0;
    step();

    // Clean frame: latency, first cell, total length and write count.
    writes = 0;
    start_frame();
    check("b_c1", {62'h0, busy, ch_we}, 64'h2);
    step();
    check("b_c2_we", 64'(ch_we), 64'h0);
    step();
    check("b_c3_first", {44'h0, ch_we, ch_addr, ch_data}, {44'h0, 1'b1, 11'h000, 8'h31});
    wait_done(3, 4609, "b_len");
    check("b_writes", 64'(writes), 64'd1536);
    check("b_cnt", 64'(frame_cnt), 64'd1);
    step();

    // Glyph cells plus a 5-cycle ack stall on cell 0x010.
    mode = 1;
    writes = 0;
    start_frame();
    n = 1;
    while (!(scan_row == 8'd1 && scan_col == 8'h10) && n < 200) begin step(); n++; end
    ch_ack = 1'b0;
    step(); step(); n += 2;
    for (int i = 0; i < 5; i++) begin
      check("c_stall", {35'h0, ch_we, ch_addr, ch_data, scan_col}, {35'h0, 1'b1, 11'h010, 8'h31, 8'h10});
      step();
      n++;
    end
    ch_ack = 1'b1;
    check("c_col_held", 64'(scan_col), 64'h10);
    wait_done(n, 4614, "c_len");
    check("c_writes", 64'(writes), 64'd1536);
    check("c_cnt", 64'(frame_cnt), 64'd2);
    mode = 0;
    step();

    // Two starts mid-frame merge into one follow-on frame.
    start_frame();
    repeat (199) step();
    fs = 1'b1; push_frame(); step();
    fs = 1'b0; step();
    fs = 1'b1; step();
    fs = 1'b0;
    wait_done(203, 4609, "d_len");
    check("d_cnt", 64'(frame_cnt), 64'd3);
    check("d_queue", 64'(sb.size()), 64'd1536);
    step();
    check("d_idle_gap", 64'(busy), 64'h0);
    step();
    check("e_restart", {47'h0, busy, scan_row, scan_col}, {47'h0, 1'b1, 8'd1, 8'd0});
    wait_done(1, 4609, "e_len");
    check("e_cnt", 64'(frame_cnt), 64'd4);

    // Start landing in the DONE cycle is kept as pending.
    fs = 1'b1; push_frame(); step();
    fs = 1'b0;
    check("f_idle", 64'(busy), 64'h0);
    step();
    check("f_restart", 64'(busy), 64'h1);
    wait_done(1, 4609, "f_len");
    check("f_cnt", 64'(frame_cnt), 64'd5);
    repeat (10) step();
    check("f_no_extra", {62'h0, busy, ch_we}, 64'h0);
    check("f_queue", 64'(sb.size()), 64'h0);

`ifdef DBG_SCAN_FREEZE_EN
    freeze = 1'b1;
    fs = 1'b1; step();
    fs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("g_frozen", {62'h0, busy, ch_we}, 64'h0);
      step();
    end
    freeze = 1'b0;
    step();
    check("g_no_pending", 64'(busy), 64'h0);
    start_frame();
    repeat (99) step();
    freeze = 1'b1;
    wait_done(100, 4609, "g_len");
    check("g_cnt", 64'(frame_cnt), 64'd6);
    freeze = 1'b0;
    step();
    check("g_queue", 64'(sb.size()), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
